// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel integer clock divider.
package clk_div_pkg;

   localparam int N_CH_DEF  = 4;
   localparam int DIV_W_DEF = 16;
   localparam int DIV_MIN   = 2;

   typedef logic [DIV_W_DEF-1:0] div_t;

   typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadow/active ratio registers, period counter, registered waveform and tick.
// Optional CLK_DIV_SYNC_EN adds sync_start, which restarts a running channel's period.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DIV_RST = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_upd,
`ifdef CLK_DIV_SYNC_EN
   input  logic             sync_start,
`endif
   output logic             clk_mul,
   output logic             tick,
   output logic             upd_pending
);

   typedef logic [DIV_W-1:0] cdiv_t;

   localparam cdiv_t ONE     = cdiv_t'(1);
   localparam cdiv_t MIN_DIV = cdiv_t'(DIV_MIN);
   localparam cdiv_t RST_DIV = cdiv_t'(DIV_RST);

   ch_state_e st, st_nx;
   cdiv_t     cnt, cnt_nx;
   cdiv_t     div_act, act_nx;
   cdiv_t     div_shd, shd_nx;
   cdiv_t     eff_div, hi;
   logic      clk_nx, tick_nx, pend_nx;
   logic      run_ok, restart;

   always_comb begin
      st_nx   = st;
      cnt_nx  = cnt;
      act_nx  = div_act;
      shd_nx  = div_shd;
      pend_nx = upd_pending;
      clk_nx  = 1'b0;
      tick_nx = 1'b0;
      run_ok  = en && (div_act >= MIN_DIV);
      restart = (st == CH_RUN) && (cnt == div_act - ONE);
`ifdef CLK_DIV_SYNC_EN
      restart = restart || ((st == CH_RUN) && sync_start);
`endif
      // Ratio that takes over at a boundary: the shadow only when an update is waiting.
      eff_div = upd_pending ? div_shd : div_act;
      hi      = div_act >> 1;

      if (!run_ok) begin
         st_nx   = CH_IDLE;
         cnt_nx  = '0;
         act_nx  = eff_div;
         pend_nx = 1'b0;
      end else if (st == CH_IDLE) begin
         st_nx   = CH_RUN;
         cnt_nx  = '0;
         clk_nx  = 1'b1;
         tick_nx = 1'b1;
      end else if (restart) begin
         act_nx  = eff_div;
         pend_nx = 1'b0;
         cnt_nx  = '0;
         // An invalid ratio becoming active parks the channel without a final tick.
         if (eff_div >= MIN_DIV) begin
            clk_nx  = 1'b1;
            tick_nx = 1'b1;
         end else begin
            st_nx = CH_IDLE;
         end
      end else begin
         cnt_nx = cnt + ONE;
         clk_nx = (cnt_nx < hi);
      end

      // A strobe always lands in the shadow; it never shortens the current period.
      if (div_upd) begin
         shd_nx  = div_in;
         pend_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st          <= CH_IDLE;
         cnt         <= '0;
         div_act     <= RST_DIV;
         div_shd     <= RST_DIV;
         clk_mul     <= 1'b0;
         tick        <= 1'b0;
         upd_pending <= 1'b0;
      end else begin
         st          <= st_nx;
         cnt         <= cnt_nx;
         div_act     <= act_nx;
         div_shd     <= shd_nx;
         clk_mul     <= clk_nx;
         tick        <= tick_nx;
         upd_pending <= pend_nx;
      end
   end

endmodule

// File: rtl/clk_division_multi.sv
// N_CH independent programmable clock-enable dividers sharing one system clock.
// Optional CLK_DIV_SYNC_EN adds a sync_start input that phase-aligns all running channels.
module clk_division_multi
   import clk_div_pkg::*;
#(
   parameter int N_CH    = N_CH_DEF,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DIV_RST = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       en,
   input  logic [N_CH*DIV_W-1:0] div_in,
   input  logic [N_CH-1:0]       div_upd,
`ifdef CLK_DIV_SYNC_EN
   input  logic                  sync_start,
`endif
   output logic [N_CH-1:0]       clk_mul,
   output logic [N_CH-1:0]       tick,
   output logic [N_CH-1:0]       upd_pending
);

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      clk_div_ch #(
         .DIV_W   (DIV_W),
         .DIV_RST (DIV_RST)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .en          (en[c]),
         .div_in      (div_in[c*DIV_W +: DIV_W]),
         .div_upd     (div_upd[c]),
`ifdef CLK_DIV_SYNC_EN
         .sync_start  (sync_start),
`endif
         .clk_mul     (clk_mul[c]),
         .tick        (tick[c]),
         .upd_pending (upd_pending[c])
      );
   end

endmodule

// File: tb/tb_clk_division_multi.sv
// Self-checking bench for clk_division_multi: directed table, corner sequences and randomized run
// against a period-level reference model. Define CLK_DIV_SYNC_EN to also exercise sync_start.
module tb_clk_division_multi;

   localparam int NC = 4;
   localparam int DW = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [NC-1:0]  en;
   logic [NC*DW-1:0] div_in;
   logic [NC-1:0]  div_upd;
   logic           sync_start = 1'b0;
   logic [NC-1:0]  clk_mul, tick, upd_pending;

   int checks = 0;
   int errors = 0;

   clk_division_multi #(.N_CH(NC), .DIV_W(DW), .DIV_RST(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .div_in      (div_in),
      .div_upd     (div_upd),
`ifdef CLK_DIV_SYNC_EN
      .sync_start  (sync_start),
`endif
      .clk_mul     (clk_mul),
      .tick        (tick),
      .upd_pending (upd_pending)
   );

   always #5 clk = ~clk;

   // Reference model: each running channel owns a period of length per, counted down via left.
   int unsigned m_act [NC];
   int unsigned m_shd [NC];
   int unsigned m_per [NC];
   int unsigned m_left[NC];
   bit          m_run [NC];
   bit          m_pend[NC];
   logic [NC-1:0] e_clk, e_tick, e_pend;

   function automatic void model_reset();
      for (int c = 0; c < NC; c++) begin
         m_act[c] = 10; m_shd[c] = 10; m_per[c] = 0; m_left[c] = 0;
         m_run[c] = 0;  m_pend[c] = 0;
      end
      e_clk = '0; e_tick = '0; e_pend = '0;
   endfunction

   function automatic void model_edge(logic [NC-1:0] en_v, logic [NC-1:0] upd_v,
                                      logic [NC*DW-1:0] din_v, logic sync_v);
      for (int c = 0; c < NC; c++) begin
         bit start = 0;
         int unsigned elapsed;
         if (!en_v[c] || m_act[c] < 2) begin
            m_run[c] = 0;
            if (m_pend[c]) m_act[c] = m_shd[c];
            m_pend[c] = 0;
         end else if (!m_run[c]) begin
            start = 1;
         end else if (m_left[c] == 1 || sync_v) begin
            if (m_pend[c]) m_act[c] = m_shd[c];
            m_pend[c] = 0;
            if (m_act[c] < 2) m_run[c] = 0;
            else start = 1;
         end else begin
            m_left[c] = m_left[c] - 1;
         end
         if (start) begin
            m_run[c] = 1; m_per[c] = m_act[c]; m_left[c] = m_act[c];
         end
         if (m_run[c]) begin
            elapsed   = m_per[c] - m_left[c];
            e_clk[c]  = (elapsed < m_per[c] / 2);
            e_tick[c] = (elapsed == 0);
         end else begin
            e_clk[c] = 0; e_tick[c] = 0;
         end
         if (upd_v[c]) begin
            m_shd[c] = int'(din_v[c*DW +: DW]); m_pend[c] = 1;
         end
         e_pend[c] = m_pend[c];
      end
   endfunction

   task automatic chk(string nm, logic [NC-1:0] got, logic [NC-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_int(string nm, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // One clock: model follows the sampled inputs, outputs checked on the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_edge(en, div_upd, div_in, sync_start);
      @(negedge clk);
      chk("clk_mul", clk_mul, e_clk);
      chk("tick", tick, e_tick);
      chk("upd_pending", upd_pending, e_pend);
   endtask

   typedef struct {
      logic [NC-1:0] en;
      logic [NC-1:0] clk;
      logic [NC-1:0] tck;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int pc, n, hc, tc;
      bit seen;

      tbl[0]  = '{4'b0000, 4'b0000, 4'b0000};
      tbl[1]  = '{4'b0001, 4'b0001, 4'b0001};
      tbl[2]  = '{4'b0001, 4'b0001, 4'b0000};
      tbl[3]  = '{4'b0001, 4'b0001, 4'b0000};
      tbl[4]  = '{4'b0001, 4'b0001, 4'b0000};
      tbl[5]  = '{4'b0001, 4'b0001, 4'b0000};
      tbl[6]  = '{4'b0001, 4'b0000, 4'b0000};
      tbl[7]  = '{4'b0001, 4'b0000, 4'b0000};
      tbl[8]  = '{4'b0001, 4'b0000, 4'b0000};
      tbl[9]  = '{4'b0001, 4'b0000, 4'b0000};
      tbl[10] = '{4'b0001, 4'b0000, 4'b0000};
      tbl[11] = '{4'b0001, 4'b0001, 4'b0001};
      tbl[12] = '{4'b0001, 4'b0001, 4'b0000};

      reset = 1'b1; en = '0; div_upd = '0; div_in = '0;
      model_reset();
      #1;
      chk("rst_clk_mul", clk_mul, '0);
      chk("rst_tick", tick, '0);
      chk("rst_pending", upd_pending, '0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Channel 0 at the reset ratio of 10.
      for (int i = 0; i < 13; i++) begin
         en = tbl[i].en;
         cyc();
         chk($sformatf("tbl%0d_clk", i), clk_mul, tbl[i].clk);
         chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tck);
      end

      // Channel 1 loaded with 7 while idle, then enabled.
      div_in[1*DW +: DW] = 16'd7; div_upd = 4'b0010;
      cyc();
      div_upd = '0;
      cyc();
      en = 4'b0011;
      hc = 0; tc = 0;
      for (int i = 0; i < 21; i++) begin
         cyc();
         hc += int'(clk_mul[1]); tc += int'(tick[1]);
      end
      chk_int("ch1_high_cycles", hc, 9);
      chk_int("ch1_ticks", tc, 3);

      // Channel 0: update to 4 landing at cnt = 3.
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (m_run[0] && (m_per[0] - m_left[0]) == 2) seen = 1;
         else cyc();
      end
      chk_int("ch0_align_found", int'(seen), 1);
      div_in[0 +: DW] = 16'd4; div_upd = 4'b0001;
      cyc();
      div_upd = '0;
      pc = int'(upd_pending[0]);
      for (int i = 0; i < 20 && upd_pending[0]; i++) begin
         cyc();
         pc += int'(upd_pending[0]);
      end
      chk_int("ch0_pending_cycles", pc, 7);
      chk("ch0_boundary_tick", tick & 4'b0001, 4'b0001);
      hc = int'(clk_mul[0]); n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (tick[0]) break;
         n++; hc += int'(clk_mul[0]);
      end
      chk_int("ch0_new_period", n + 1, 4);
      chk_int("ch0_new_high", hc, 2);

      // Channel 2: invalid ratio 1 parks it, ratio 2 resumes a 1/1 toggle.
      en = 4'b0111;
      cyc();
      div_in[2*DW +: DW] = 16'd1; div_upd = 4'b0100;
      cyc();
      div_upd = '0;
      for (int i = 0; i < 15 && upd_pending[2]; i++) cyc();
      tc = 0; hc = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         tc += int'(tick[2]); hc += int'(clk_mul[2]);
      end
      chk_int("ch2_parked_ticks", tc, 0);
      chk_int("ch2_parked_high", hc, 0);
      div_in[2*DW +: DW] = 16'd2; div_upd = 4'b0100;
      cyc();
      div_upd = '0;
      for (int i = 0; i < 5 && upd_pending[2]; i++) cyc();
      tc = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         tc += int'(tick[2]);
      end
      chk_int("ch2_ratio2_ticks", tc, 4);

      // Asynchronous reset while channel 0 is high.
      for (int i = 0; i < 8 && !clk_mul[0]; i++) cyc();
      chk("pre_reset_high", clk_mul & 4'b0001, 4'b0001);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("async_clk_mul", clk_mul, '0);
      chk("async_tick", tick, '0);
      chk("async_pending", upd_pending, '0);
      @(negedge clk);
      reset = 1'b0;
      cyc();
      chk("restart_ticks", tick, 4'b0111);
      for (int i = 0; i < 12; i++) cyc();

`ifdef CLK_DIV_SYNC_EN
      // Ratios 10/7/6/4 then a sync pulse aligns every tick.
      en = '0;
      div_in = {16'd4, 16'd6, 16'd7, 16'd10}; div_upd = 4'b1111;
      cyc();
      div_upd = '0;
      cyc();
      en = 4'b1111;
      for (int i = 0; i < 13; i++) cyc();
      sync_start = 1'b1;
      cyc();
      sync_start = 1'b0;
      chk("sync_ticks", tick, 4'b1111);
      chk("sync_clk_mul", clk_mul, 4'b1111);
      for (int i = 0; i < 25; i++) cyc();
`endif

      // Randomized traffic against the model.
      en = 4'b1111;
      for (int i = 0; i < 500; i++) begin
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 24) == 0) en[c] = ~en[c];
            div_upd[c] = ($urandom_range(0, 15) == 0);
            div_in[c*DW +: DW] = DW'($urandom_range(0, 12));
         end
`ifdef CLK_DIV_SYNC_EN
         sync_start = ($urandom_range(0, 39) == 0);
`endif
         cyc();
      end
      div_upd = '0;
      sync_start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
